// File: rtl/clock_monitor.sv
// Clock monitor: synchronizes a slow clock and emits rise/fall ticks. It measures the
// period and high time and flags loss of clock. The optional period tolerance check is
// compiled in only when CLKMON_TOL_CHECK_EN is defined.
module clock_monitor #(
  parameter int CNT_W         = 32,
  parameter int SYNC_STAGES   = 2,
  parameter int TIMEOUT       = 1024,
  parameter int EXPECT_PERIOD = 22,
  parameter int TOLERANCE     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clk_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             clk_lost,
  output logic             freq_err
);

  typedef enum logic [1:0] {IDLE, WAIT_FIRST, MEASURE, LOST} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT < 1 ||
      EXPECT_PERIOD < 0 || TOLERANCE < 0) begin : g_param_check
    $error("clock_monitor: parameter out of range");
  end

  logic [SYNC_STAGES-1:0] sync_reg, sync_next;
  logic                   prev_reg;
  logic                   sync_bit, rise, fall;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next, cnt_inc;
  logic [CNT_W-1:0]       period_reg, period_next;
  logic [CNT_W-1:0]       high_reg, high_next;
  logic                   rise_reg, rise_next;
  logic                   fall_reg, fall_next;
  logic                   valid_reg, valid_next;
  logic                   lost_reg, lost_next;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_next[gi] = clk_in;
      end else begin : g_chain
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  assign sync_bit = sync_reg[SYNC_STAGES-1];
  assign rise     = sync_bit & ~prev_reg;
  assign fall     = ~sync_bit & prev_reg;
  assign cnt_inc  = cnt_reg + CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg   <= '0;
      prev_reg   <= 1'b0;
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      period_reg <= '0;
      high_reg   <= '0;
      rise_reg   <= 1'b0;
      fall_reg   <= 1'b0;
      valid_reg  <= 1'b0;
      lost_reg   <= 1'b0;
    end else begin
      sync_reg   <= sync_next;
      prev_reg   <= sync_bit;
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      period_reg <= period_next;
      high_reg   <= high_next;
      rise_reg   <= rise_next;
      fall_reg   <= fall_next;
      valid_reg  <= valid_next;
      lost_reg   <= lost_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    period_next = period_reg;
    high_next   = high_reg;
    valid_next  = 1'b0;
    lost_next   = lost_reg;
    rise_next   = rise && (state_reg != IDLE);
    fall_next   = fall && (state_reg != IDLE);

    // Dropping enable discards any measurement in flight, even one completing this cycle.
    if (!enable) begin
      state_next = IDLE;
      cnt_next   = '0;
      lost_next  = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = WAIT_FIRST;
          cnt_next   = '0;
        end
        WAIT_FIRST: begin
          if (rise) begin
            cnt_next   = '0;
            state_next = MEASURE;
          end else if (cnt_reg == CNT_LAST) begin
            state_next = LOST;
            lost_next  = 1'b1;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        MEASURE: begin
          if (fall) begin
            high_next = cnt_inc;
          end
          if (rise) begin
            period_next = cnt_inc;
            valid_next  = 1'b1;
            cnt_next    = '0;
          end else if (cnt_reg == CNT_LAST) begin
            state_next = LOST;
            lost_next  = 1'b1;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        LOST: begin
          // The counter stays parked; the interval up to the next rise is unknown.
          if (rise) begin
            cnt_next   = '0;
            lost_next  = 1'b0;
            state_next = MEASURE;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
          lost_next  = 1'b0;
        end
      endcase
    end
  end

  assign rise_pulse   = rise_reg;
  assign fall_pulse   = fall_reg;
  assign period       = period_reg;
  assign high_time    = high_reg;
  assign period_valid = valid_reg;
  assign clk_lost     = lost_reg;

`ifdef CLKMON_TOL_CHECK_EN
  localparam logic [CNT_W-1:0] LO_BOUND =
    (EXPECT_PERIOD > TOLERANCE) ? CNT_W'(EXPECT_PERIOD - TOLERANCE) : '0;
  localparam logic [CNT_W-1:0] HI_BOUND = CNT_W'(EXPECT_PERIOD + TOLERANCE);

  logic ferr_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ferr_reg <= 1'b0;
    end else if (state_next == IDLE) begin
      ferr_reg <= 1'b0;
    end else if (valid_next) begin
      ferr_reg <= (period_next < LO_BOUND) || (period_next > HI_BOUND);
    end
  end

  assign freq_err = ferr_reg | lost_reg;
`else
  assign freq_err = 1'b0;
`endif

endmodule

// File: tb/tb_clock_monitor.sv
// Bench for clock_monitor: directed scenarios plus random clk_in traffic, checked every
// cycle against a timestamp-based model of edges, periods and timeouts.
module tb_clock_monitor;
  localparam int CNT_W         = 32;
  localparam int SYNC_STAGES   = 2;
  localparam int TIMEOUT       = 1024;
  localparam int EXPECT_PERIOD = 22;
  localparam int TOLERANCE     = 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             enable = 1'b0;
  logic             clk_in = 1'b0;
  logic             rise_pulse, fall_pulse, period_valid, clk_lost, freq_err;
  logic [CNT_W-1:0] period, high_time;

  clock_monitor #(
    .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT),
    .EXPECT_PERIOD(EXPECT_PERIOD), .TOLERANCE(TOLERANCE)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .clk_in(clk_in),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .period(period),
    .high_time(high_time), .period_valid(period_valid), .clk_lost(clk_lost),
    .freq_err(freq_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: clk_in history per sampled edge plus timestamps of events.
  logic hist [SYNC_STAGES+2];
  bit   m_active, m_armed, m_lost, m_ferr;
  int   m_anchor, m_period, m_high;
  bit   e_rise, e_fall, e_pv;
  int   edge_n = 0;

  // Observation bookkeeping for directed checks.
  int   pv_seen = 0;
  int   last_rise_edge = 0;
  int   lost_edge = 0;
  bit   lost_prev = 0;
  bit   watch_rise = 0;
  int   rise_seen_edge = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit out_of_tol(input int p);
    int lo;
    lo = (EXPECT_PERIOD > TOLERANCE) ? EXPECT_PERIOD - TOLERANCE : 0;
    return (p < lo) || (p > EXPECT_PERIOD + TOLERANCE);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SYNC_STAGES + 2; i++) hist[i] = 1'b0;
    m_active = 0; m_armed = 0; m_lost = 0; m_ferr = 0;
    m_anchor = 0; m_period = 0; m_high = 0;
    e_rise = 0; e_fall = 0; e_pv = 0;
  endtask

  task automatic check_outputs();
    logic exp_ferr;
`ifdef CLKMON_TOL_CHECK_EN
    exp_ferr = m_ferr | m_lost;
`else
    exp_ferr = 1'b0;
`endif
    chk("rise_pulse", rise_pulse, e_rise);
    chk("fall_pulse", fall_pulse, e_fall);
    chk("period_valid", period_valid, e_pv);
    chk("period", period, m_period);
    chk("high_time", high_time, m_high);
    chk("clk_lost", clk_lost, m_lost);
    chk("freq_err", freq_err, exp_ferr);
  endtask

  // One clock cycle: drive inputs, take the edge, advance the model, compare.
  task automatic step(input logic en, input logic cin);
    bit rise_det, fall_det;
    enable = en;
    clk_in = cin;
    @(posedge clk);
    #1;
    edge_n++;
    for (int i = SYNC_STAGES + 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = cin;
    rise_det = hist[SYNC_STAGES] & ~hist[SYNC_STAGES+1];
    fall_det = ~hist[SYNC_STAGES] & hist[SYNC_STAGES+1];
    e_rise = m_active && rise_det;
    e_fall = m_active && fall_det;
    e_pv   = 0;
    if (!en) begin
      m_active = 0; m_armed = 0; m_lost = 0; m_ferr = 0;
    end else if (!m_active) begin
      m_active = 1; m_anchor = edge_n; m_armed = 0; m_lost = 0;
    end else if (rise_det) begin
      if (m_armed && !m_lost) begin
        m_period = edge_n - m_anchor;
        e_pv     = 1;
        m_ferr   = out_of_tol(m_period);
      end
      m_anchor = edge_n; m_armed = 1; m_lost = 0;
    end else begin
      if (fall_det && m_armed && !m_lost) m_high = edge_n - m_anchor;
      if (!m_lost && (edge_n - m_anchor) == TIMEOUT) m_lost = 1;
    end
    check_outputs();
    if (period_valid === 1'b1) pv_seen++;
    if (rise_pulse === 1'b1) last_rise_edge = edge_n;
    if (watch_rise && rise_pulse === 1'b1) begin
      rise_seen_edge = edge_n;
      watch_rise = 0;
    end
    if (clk_lost === 1'b1 && !lost_prev) lost_edge = edge_n;
    lost_prev = (clk_lost === 1'b1);
  endtask

  task automatic toggle(input int hi, input int lo, input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < hi; i++) step(1'b1, 1'b1);
      for (int i = 0; i < lo; i++) step(1'b1, 1'b0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rise"}, rise_pulse, 1'b0);
    chk({tag, "_fall"}, fall_pulse, 1'b0);
    chk({tag, "_period"}, period, '0);
    chk({tag, "_high"}, high_time, '0);
    chk({tag, "_valid"}, period_valid, 1'b0);
    chk({tag, "_lost"}, clk_lost, 1'b0);
    chk({tag, "_ferr"}, freq_err, 1'b0);
  endtask

  int  drive_edge;
  int  hi_t [4] = '{10, 11, 10, 12};
  int  lo_t [4] = '{11, 12, 10, 12};
  bit  bad_t [4] = '{0, 0, 1, 1};
  logic exp_f;
  logic lvl;

  initial begin
    model_reset();
    // Plan 1: reset state, then enabled with clk_in stuck low until timeout.
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    for (int i = 0; i < TIMEOUT + 6; i++) step(1'b1, 1'b0);
    chk("p1_lost", clk_lost, 1'b1);

    // Plan 2: divider pattern, 11 high / 11 low.
    pv_seen = 0;
    watch_rise = 1;
    drive_edge = edge_n + 1;
    toggle(11, 11, 5);
    chk("p2_latency", rise_seen_edge - drive_edge + 1, SYNC_STAGES + 1);
    chk("p2_pv_count", pv_seen, 4);
    chk("p2_period", period, 22);
    chk("p2_high", high_time, 11);

    // Plan 3: stop high, then restart.
    step(1'b1, 1'b1);
    for (int i = 0; i < TIMEOUT + 20; i++) step(1'b1, 1'b1);
    chk("p3_lost", clk_lost, 1'b1);
    chk("p3_lost_delay", lost_edge - last_rise_edge, TIMEOUT);
    pv_seen = 0;
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0);
    toggle(11, 11, 3);
    chk("p3_lost_clear", clk_lost, 1'b0);
    chk("p3_pv_count", pv_seen, 2);

    // Plan 4: enable drops on the very cycle a rise is detected.
    for (int i = 0; i < SYNC_STAGES; i++) step(1'b1, 1'b1);
    pv_seen = 0;
    step(1'b0, 1'b1);
    chk("p4_no_pv", period_valid, 1'b0);
    chk("p4_pv_count", pv_seen, 0);
    chk("p4_period", period, 22);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    pv_seen = 0;
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0);
    toggle(11, 11, 2);
    chk("p4_reenable_pv", pv_seen, 1);

    // Plan 5: asynchronous reset mid-period.
    toggle(11, 6, 1);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("p5_async");
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("p5_hold");
    model_reset();
    rst = 1'b1;
    pv_seen = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    toggle(11, 11, 2);
    chk("p5_first_unreported", pv_seen, 1);

    // Plan 6: periods around the nominal value.
    for (int t = 0; t < 4; t++) begin
      toggle(hi_t[t], lo_t[t], 3);
`ifdef CLKMON_TOL_CHECK_EN
      exp_f = bad_t[t];
`else
      exp_f = 1'b0;
`endif
      chk("p6_period", period, hi_t[t] + lo_t[t]);
      chk("p6_freq_err", freq_err, exp_f);
    end

    // Random traffic: varying duty, occasional stalls and enable drops.
    lvl = 1'b0;
    for (int s = 0; s < 250; s++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        for (int i = 0; i < TIMEOUT + $urandom_range(0, 10); i++) step(1'b1, lvl);
      end else if (r < 8) begin
        for (int i = 0; i < $urandom_range(1, 5); i++) step(1'b0, lvl);
      end else begin
        lvl = ~lvl;
        for (int i = 0; i < $urandom_range(1, 30); i++) step(1'b1, lvl);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/clock_monitor.md
Name: clock_monitor

Overview:
Receive-side companion to the team's divided-clock generator. Samples a slow, possibly asynchronous clock (clk_in) in the system clock domain and synchronizes it. Emits single-cycle rise/fall tick pulses, measures period and high time in system-clock cycles, and flags loss of clock. Sits between the divider or other slow-clock sources and the state-machine logic that consumes ticks.

Parameters:
CNT_W, 32, width of the internal cycle counter and the measurement outputs.
SYNC_STAGES, 2, number of synchronizer flops on clk_in; legal range 2..4.
TIMEOUT, 1024, system-clock cycles without a rising edge before clk_lost asserts; must be ≤ 2^CNT_W-1.
EXPECT_PERIOD, 22, nominal clk_in period in clk cycles; used only with the optional feature.
TOLERANCE, 1, allowed ± deviation from EXPECT_PERIOD; used only with the optional feature.

Ports:
clk  input  1  system clock; all logic is on its rising edge.
rst  input  1  reset, asynchronous, active-low: asserted when 0, deasserted synchronously to clk.
enable  input  1  1 means monitoring is active; 0 forces IDLE.
clk_in  input  1  monitored slow clock, asynchronous to clk.
rise_pulse  output  1  one-cycle pulse for each synchronized rising edge.
fall_pulse  output  1  one-cycle pulse for each synchronized falling edge.
period  output  CNT_W  last measured rising-to-rising interval, in clk cycles.
high_time  output  CNT_W  last measured rising-to-falling interval, in clk cycles.
period_valid  output  1  one-cycle pulse when period is updated.
clk_lost  output  1  level; 1 while clk_in is considered stopped.
freq_err  output  1  level; result of the tolerance check (see Optional Feature).

Behaviour:
- Reset (rst=0): every output is 0, the counter is 0, all synchronizer flops and the edge register are 0, and the state is IDLE.
- Synchronizer and edge detection:
  - clk_in passes through SYNC_STAGES flops, then one previous-value register.
  - rise = sync & ~prev; fall = ~sync & prev.
  - rise_pulse/fall_pulse are registered, so latency from a clk_in transition to the pulse is SYNC_STAGES+1 clk cycles.
  - Pulses are generated in every state except IDLE.
- States are IDLE, WAIT_FIRST, MEASURE and LOST.
- IDLE:
  - cnt=0; no pulses; clk_lost=0; period and high_time are held.
  - enable=1 moves to WAIT_FIRST on the next cycle.
- WAIT_FIRST:
  - cnt increments each cycle.
  - On rise: cnt←0, go to MEASURE, no period_valid.
  - If cnt reaches TIMEOUT-1 with no rise: go to LOST.
- MEASURE:
  - cnt increments each cycle.
  - On fall: high_time←cnt+1.
  - On rise: period←cnt+1, period_valid=1 for that cycle, cnt←0.
  - If cnt reaches TIMEOUT-1 with no rise: go to LOST and set clk_lost=1 on the transition.
- LOST:
  - cnt is held (saturates) and never wraps; clk_lost=1.
  - On rise: clk_lost←0, cnt←0, go to MEASURE, no period_valid (the interval is unknown).
- enable=0 in any state: go to IDLE next cycle, clk_lost←0, a pending measurement is discarded.
- Simultaneous rise and enable fall: enable wins and no period_valid is emitted.
- rise and fall can never both occur in the same cycle, because the edge detector compares a single bit.
- clk_in high or low time shorter than one clk period may be missed. This is allowed and no error is flagged.
- Reset mid-measurement returns everything to reset values immediately (asynchronous); the first period after reset is never reported.

Optional Feature:
Macro CLKMON_TOL_CHECK_EN.
- Defined:
  - On each period_valid, freq_err←1 if period < EXPECT_PERIOD-TOLERANCE or period > EXPECT_PERIOD+TOLERANCE, else freq_err←0.
  - Compare the newly captured value; use unsigned arithmetic with the lower bound clamped at 0.
  - freq_err is also forced to 1 while clk_lost=1, and cleared in IDLE and on reset.
- Not defined: freq_err is tied to 0 and no comparator logic exists; the port list is unchanged.

Test Plan:
1. Reset with rst=0 then release, enable=1, clk_in held low → every output stays 0; after 1024 cycles clk_lost=1.
2. clk_in toggles every 11 clk cycles (divider pattern), enable=1 → first rise gives no period_valid; each later rise gives period_valid with period=22 and high_time=11; rise_pulse arrives 3 cycles after the clk_in edge.
3. Stop clk_in high mid-run → clk_lost=1 exactly TIMEOUT cycles after the last rise_pulse; restart toggling → clk_lost=0 at the first rise, and the first period_valid comes at the second rise.
4. Drop enable during MEASURE, coincident with a rise → no period_valid, state returns to IDLE, period still 22; re-enable → the next report needs two rises.
5. Assert rst low for 1 cycle mid-period → all outputs 0 immediately (asynchronous) and the state is IDLE.
6. With CLKMON_TOL_CHECK_EN defined, EXPECT_PERIOD=22, TOLERANCE=1: periods 21, 23 → freq_err=0; periods 20, 24 → freq_err=1; without the macro freq_err stays 0 throughout.
